// File: rtl/p_hit_pkg.sv
// Shared types for the p_hit_1 triangle scheduler.
// State encoding, far-plane constant and vec3 bundle.
package p_hit_pkg;

    localparam int VEC_BITS = 32;

    localparam logic [VEC_BITS-1:0] T_FAR = 32'h7FFF_FFFF;

    typedef logic [2:0][VEC_BITS-1:0] vec3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/p_hit_min_track.sv
// Running minimum of positive t results with index.
// Ties keep the earlier index (strict less-than).
module p_hit_min_track
    import p_hit_pkg::*;
#(
    parameter int D_BITS   = 32,
    parameter int IDX_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                update,
    input  logic [D_BITS-1:0]   t,
    input  logic [IDX_BITS-1:0] idx,
    output logic                hit,
    output logic [D_BITS-1:0]   best_t,
    output logic [IDX_BITS-1:0] best_idx
);

    localparam logic [D_BITS-1:0] FAR = {1'b0, {(D_BITS-1){1'b1}}};
    localparam logic [D_BITS-1:0] ZERO = '0;

    logic better;

    assign better = update
                 && ($signed(t) > $signed(ZERO))
                 && ($signed(t) < $signed(best_t));

    // Clear on job start, otherwise keep the closest positive t seen.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            hit      <= 1'b0;
            best_t   <= FAR;
            best_idx <= '0;
        end else if (better) begin
            hit      <= 1'b1;
            best_t   <= t;
            best_idx <= idx;
        end
    end

endmodule

// File: rtl/p_hit_tri_sched.sv
// Per-ray triangle scheduler feeding both p_hit_1 halves.
// Issues under backpressure/credit limit, retires in order.
module p_hit_tri_sched
    import p_hit_pkg::*;
#(
    parameter int D_BITS       = 32,
    parameter int Q_BITS       = 16,
    parameter int IDX_BITS     = 16,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IDX_BITS-1:0]    tri_count,
    input  logic [2:0][D_BITS-1:0] ray_origin,
    input  logic [2:0][D_BITS-1:0] ray_dir,
    input  logic                   tri_valid,
    output logic                   tri_ready,
    input  logic [2:0][D_BITS-1:0] tri_normal,
    input  logic [2:0][D_BITS-1:0] tri_v0,
    output logic [2:0][D_BITS-1:0] ph_normal_1,
    output logic [2:0][D_BITS-1:0] ph_normal_2,
    output logic [2:0][D_BITS-1:0] ph_v0,
    output logic [2:0][D_BITS-1:0] ph_origin,
    output logic [2:0][D_BITS-1:0] ph_dir,
    input  logic [1:0]             ph_in_full,
    output logic [1:0]             ph_in_wr_en,
    input  logic [D_BITS-1:0]      ph_out,
    input  logic                   ph_out_empty,
    output logic                   ph_out_rd_en,
    output logic                   busy,
    output logic                   done,
    output logic                   hit,
    output logic [D_BITS-1:0]      hit_t,
    output logic [IDX_BITS-1:0]    hit_idx
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    if (Q_BITS >= D_BITS) begin : g_qchk
        $error("Q_BITS must be below D_BITS");
    end

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] cnt_q, issued_q, retired_q;
    logic [CW-1:0]       inflight_q;
    logic                run, load, issue, retire;

    assign run   = (state_q == RUN);
    assign load  = (state_q == IDLE) && start;

    assign tri_ready = run
                    && (issued_q < cnt_q)
                    && !ph_in_full[0]
                    && !ph_in_full[1]
                    && (inflight_q < CW'(MAX_INFLIGHT));

    assign issue        = tri_valid && tri_ready;
    assign ph_in_wr_en  = {2{issue}};
    assign retire       = run && !ph_out_empty && (retired_q < issued_q);
    assign ph_out_rd_en = retire;

    assign ph_normal_1 = tri_normal;
    assign ph_normal_2 = tri_normal;
    assign ph_v0       = tri_v0;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and job status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = (tri_count == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (retired_q == cnt_q) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ray latch plus issue/retire/credit counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ph_origin  <= '0;
            ph_dir     <= '0;
            cnt_q      <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            inflight_q <= '0;
        end else if (load) begin
            ph_origin  <= ray_origin;
            ph_dir     <= ray_dir;
            cnt_q      <= tri_count;
            issued_q   <= '0;
            retired_q  <= '0;
            inflight_q <= '0;
        end else begin
            if (issue)  issued_q  <= issued_q + 1'b1;
            if (retire) retired_q <= retired_q + 1'b1;
            if (issue && !retire)      inflight_q <= inflight_q + 1'b1;
            else if (!issue && retire) inflight_q <= inflight_q - 1'b1;
        end
    end

    p_hit_min_track #(
        .D_BITS   (D_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_min (
        .clock    (clock),
        .reset    (reset),
        .clear    (load),
        .update   (retire),
        .t        (ph_out),
        .idx      (retired_q),
        .hit      (hit),
        .best_t   (hit_t),
        .best_idx (hit_idx)
    );

endmodule
